pe_acc: RTL and testbench
=========================

PE_ACC -- requirements
Module: pe_acc

Interface
REQ-001 SHALL have parameter DW, default 8, meaning operand width in bits.
REQ-002 SHALL have parameter AW, default 24, meaning accumulator and psum width in bits; legal only if AW >= 2*DW.
REQ-003 SHALL have parameter SIGNED, default 1, meaning 1 = two's-complement operands and accumulator, 0 = unsigned.
REQ-004 SHALL have parameter SAT, default 1, meaning 1 = saturating accumulate, 0 = wrap-around accumulate.
REQ-005 SHALL have ports, one per line (name, direction, width, meaning):
- clk  in  1  clock.
- reset  in  1  synchronous, active-high.
- clear  in  1  start new tile, zero the accumulator.
- drain  in  1  start result drain pulse.
- chain_top  in  1  static tie; 1 = PE is top of its column.
- a_in  in  DW  left operand.
- a_vld_in  in  1  a_in valid.
- b_in  in  DW  top operand.
- b_vld_in  in  1  b_in valid.
- psum_in  in  AW  drained result from PE above.
- psum_vld_in  in  1  psum_in valid.
- psum_last_in  in  1  psum_in is last of stream.
- a_out  out  DW  registered a_in to right neighbour.
- a_vld_out  out  1  registered a_vld_in.
- b_out  out  DW  registered b_in to lower neighbour.
- b_vld_out  out  1  registered b_vld_in.
- psum_out  out  AW  drained result to PE below.
- psum_vld_out  out  1  psum_out valid.
- psum_last_out  out  1  psum_out is last of stream.
- busy  out  1  1 while in DRAIN.
- ovf  out  1  sticky overflow or saturation flag.

Function
REQ-006 SHALL implement an FSM with states IDLE, COMPUTE and DRAIN.
REQ-007 SHALL transition IDLE->COMPUTE on clear, COMPUTE->DRAIN on drain, and IDLE->DRAIN on drain.
REQ-008 SHALL give drain priority over clear when both are asserted in IDLE/COMPUTE; that cycle's clear is ignored.
REQ-009 SHALL ignore clear and drain while in DRAIN.
REQ-010 SHALL register a_out/a_vld_out/b_out/b_vld_out from the inputs every cycle in all states, with 1-cycle latency.
REQ-011 SHALL, in COMPUTE with a_vld_in=1 and b_vld_in=1, update acc <= acc + a_in*b_in.
- Product is 2*DW wide, sign- or zero-extended per SIGNED to AW.
REQ-012 SHALL leave acc unchanged in COMPUTE if either valid is low, and in IDLE and DRAIN.
REQ-013 SHALL, with SAT=1, clamp the sum to the AW range (signed: -2^(AW-1)..2^(AW-1)-1; unsigned: 0..2^AW-1) and set ovf on clamp.
REQ-014 SHALL, with SAT=0, wrap the sum modulo 2^AW and set ovf on a true overflow.
REQ-015 SHALL, on clear accepted in IDLE/COMPUTE, set acc to 0 and ovf to 0.
- A same-cycle valid MAC (COMPUTE only) loads acc = product, not 0.
REQ-016 SHALL, on entering DRAIN at cycle t, present psum_out=acc and psum_vld_out=1 at t+1, with psum_last_out=chain_top.
REQ-017 SHALL return DRAIN->IDLE after that cycle if chain_top=1.
REQ-018 SHALL, if chain_top=0, forward psum_in/psum_vld_in/psum_last_in to the outputs with 1-cycle latency after the own-result cycle.
- Return to IDLE in the cycle after forwarding a word with psum_last_in=1.
REQ-019 SHALL drive psum_out=0 and psum_last_out=0 whenever psum_vld_out=0.
REQ-020 SHALL ignore psum inputs outside DRAIN.
REQ-021 SHALL hold acc through drain, so a second drain without clear re-emits the same value.
REQ-022 SHALL assert busy exactly while state=DRAIN.

Reset
REQ-023 SHALL, on reset, set state=IDLE, acc=0, ovf=0, busy=0, and all data/valid/last outputs to 0 from the next edge.
REQ-024 SHALL have reset override clear, drain and any in-progress DRAIN; an aborted stream emits no further words.

Verification
REQ-025 Bench SHALL cover: reset asserted 2 cycles -> all outputs 0, busy=0, ovf=0.
REQ-026 Bench SHALL cover: defaults, chain_top=1, clear, MACs (3,4),(-2,5),(7,7), then drain -> one cycle later psum_out=51, vld=1, last=1; busy high 1 cycle.
REQ-027 Bench SHALL cover: AW=16, SAT=1, clear, three MACs (127,127) -> acc 16129, 32258, then 32767 clamped; ovf=1; next clear -> ovf=0.
REQ-028 Bench SHALL cover: a_vld_in=1, b_vld_in=0, a_in=9 -> acc unchanged; a_out=9 and a_vld_out=1 one cycle later.
REQ-029 Bench SHALL cover: 3-PE column with accs 10 (bottom), 20, 30 (top, chain_top=1), common drain -> bottom psum_out 10, 20, 30 on consecutive cycles, last only with 30, bottom busy 3 cycles.
REQ-030 Bench SHALL cover: reset in 2nd cycle of bottom-PE drain -> psum_vld_out=0 next cycle, state IDLE, acc=0.

Source files
------------

// File: rtl/pe_acc.sv
// rtl/pe_acc.sv - systolic-array processing element: MAC accumulator with column psum drain chain
module pe_acc #(
    parameter int DW     = 8,
    parameter int AW     = 24,
    parameter int SIGNED = 1,
    parameter int SAT    = 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clear,
    input  logic          drain,
    input  logic          chain_top,
    input  logic [DW-1:0] a_in,
    input  logic          a_vld_in,
    input  logic [DW-1:0] b_in,
    input  logic          b_vld_in,
    input  logic [AW-1:0] psum_in,
    input  logic          psum_vld_in,
    input  logic          psum_last_in,
    output logic [DW-1:0] a_out,
    output logic          a_vld_out,
    output logic [DW-1:0] b_out,
    output logic          b_vld_out,
    output logic [AW-1:0] psum_out,
    output logic          psum_vld_out,
    output logic          psum_last_out,
    output logic          busy,
    output logic          ovf
);
    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] COMPUTE = 2'd1;
    localparam logic [1:0] DRAIN   = 2'd2;

    localparam logic [AW-1:0] SMAX = {1'b0, {(AW-1){1'b1}}};
    localparam logic [AW-1:0] SMIN = {1'b1, {(AW-1){1'b0}}};

    logic [1:0]    state;
    logic          own_pending;
    logic [AW-1:0] acc;
    logic [AW-1:0] a_ext, b_ext, prod, clamp, acc_next;
    logic [AW:0]   sum;
    logic          mac, over, clear_acc;

    // Operands are extended to AW before multiplying; the true product fits in
    // 2*DW <= AW bits, so the low AW bits are already the extended product.
    assign a_ext = {{(AW-DW){(SIGNED != 0) && a_in[DW-1]}}, a_in};
    assign b_ext = {{(AW-DW){(SIGNED != 0) && b_in[DW-1]}}, b_in};
    assign prod  = a_ext * b_ext;
    assign sum   = {(SIGNED != 0) && acc[AW-1], acc} + {(SIGNED != 0) && prod[AW-1], prod};

    always_comb begin
        over     = 1'b0;
        clamp    = '1;
        acc_next = sum[AW-1:0];
        if (SIGNED != 0) begin
            over  = sum[AW] ^ sum[AW-1];
            clamp = sum[AW] ? SMIN : SMAX;
        end else begin
            over  = sum[AW];
        end
        if (over && SAT != 0)
            acc_next = clamp;
    end

    assign mac       = (state == COMPUTE) && a_vld_in && b_vld_in;
    assign clear_acc = (state != DRAIN) && clear && !drain;
    assign busy      = (state == DRAIN);

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            own_pending   <= 1'b0;
            acc           <= '0;
            ovf           <= 1'b0;
            a_out         <= '0;
            a_vld_out     <= 1'b0;
            b_out         <= '0;
            b_vld_out     <= 1'b0;
            psum_out      <= '0;
            psum_vld_out  <= 1'b0;
            psum_last_out <= 1'b0;
        end else begin
            a_out         <= a_in;
            a_vld_out     <= a_vld_in;
            b_out         <= b_in;
            b_vld_out     <= b_vld_in;
            psum_out      <= '0;
            psum_vld_out  <= 1'b0;
            psum_last_out <= 1'b0;

            if (clear_acc) begin
                acc <= mac ? prod : '0;
                ovf <= 1'b0;
            end else if (mac) begin
                acc <= acc_next;
                if (over)
                    ovf <= 1'b1;
            end

            case (state)
                IDLE, COMPUTE: begin
                    if (drain) begin
                        state       <= DRAIN;
                        own_pending <= 1'b1;
                    end else if (clear) begin
                        state <= COMPUTE;
                    end
                end
                DRAIN: begin
                    // First DRAIN cycle emits our own result, then we relay the PEs above.
                    if (own_pending) begin
                        own_pending   <= 1'b0;
                        psum_out      <= acc;
                        psum_vld_out  <= 1'b1;
                        psum_last_out <= chain_top;
                        if (chain_top)
                            state <= IDLE;
                    end else if (psum_vld_in) begin
                        psum_out      <= psum_in;
                        psum_vld_out  <= 1'b1;
                        psum_last_out <= psum_last_in;
                        if (psum_last_in)
                            state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_pe_acc.sv
// tb/tb_pe_acc.sv - directed table-driven bench for pe_acc
module tb_pe_acc;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int passed = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // ---------------- default-parameter PE, top of column ----------------
    logic        reset, clear, drain;
    logic [7:0]  a_in, b_in;
    logic        a_vld_in, b_vld_in;
    logic [7:0]  a_out, b_out;
    logic        a_vld_out, b_vld_out, psum_vld_out, psum_last_out, busy, ovf;
    logic [23:0] psum_out;

    pe_acc dut (
        .clk(clk), .reset(reset), .clear(clear), .drain(drain), .chain_top(1'b1),
        .a_in(a_in), .a_vld_in(a_vld_in), .b_in(b_in), .b_vld_in(b_vld_in),
        .psum_in(24'h0), .psum_vld_in(1'b0), .psum_last_in(1'b0),
        .a_out(a_out), .a_vld_out(a_vld_out), .b_out(b_out), .b_vld_out(b_vld_out),
        .psum_out(psum_out), .psum_vld_out(psum_vld_out), .psum_last_out(psum_last_out),
        .busy(busy), .ovf(ovf)
    );

    // ---------------- AW=16 saturating PE ----------------
    logic        s_clear, s_drain, s_vld;
    logic [7:0]  s_a, s_b, s_aout, s_bout;
    logic        s_avo, s_bvo, s_pv, s_pl, s_busy, s_ovf;
    logic [15:0] s_psum;

    pe_acc #(.DW(8), .AW(16), .SIGNED(1), .SAT(1)) dut_s (
        .clk(clk), .reset(reset), .clear(s_clear), .drain(s_drain), .chain_top(1'b1),
        .a_in(s_a), .a_vld_in(s_vld), .b_in(s_b), .b_vld_in(s_vld),
        .psum_in(16'h0), .psum_vld_in(1'b0), .psum_last_in(1'b0),
        .a_out(s_aout), .a_vld_out(s_avo), .b_out(s_bout), .b_vld_out(s_bvo),
        .psum_out(s_psum), .psum_vld_out(s_pv), .psum_last_out(s_pl),
        .busy(s_busy), .ovf(s_ovf)
    );

    // ---------------- 3-PE column: index 0 bottom, 2 top ----------------
    logic        c_rst, c_clear, c_drain, c_vld;
    logic [7:0]  ca [3];
    logic [7:0]  c_aout [3];
    logic [7:0]  c_bout [3];
    logic        c_avo [3], c_bvo [3], c_busy [3], c_ovf [3];
    logic [23:0] c_ps [3];
    logic        c_pv [3], c_pl [3];

    pe_acc u_bot (
        .clk(clk), .reset(c_rst), .clear(c_clear), .drain(c_drain), .chain_top(1'b0),
        .a_in(ca[0]), .a_vld_in(c_vld), .b_in(8'd1), .b_vld_in(c_vld),
        .psum_in(c_ps[1]), .psum_vld_in(c_pv[1]), .psum_last_in(c_pl[1]),
        .a_out(c_aout[0]), .a_vld_out(c_avo[0]), .b_out(c_bout[0]), .b_vld_out(c_bvo[0]),
        .psum_out(c_ps[0]), .psum_vld_out(c_pv[0]), .psum_last_out(c_pl[0]),
        .busy(c_busy[0]), .ovf(c_ovf[0])
    );
    pe_acc u_mid (
        .clk(clk), .reset(c_rst), .clear(c_clear), .drain(c_drain), .chain_top(1'b0),
        .a_in(ca[1]), .a_vld_in(c_vld), .b_in(8'd1), .b_vld_in(c_vld),
        .psum_in(c_ps[2]), .psum_vld_in(c_pv[2]), .psum_last_in(c_pl[2]),
        .a_out(c_aout[1]), .a_vld_out(c_avo[1]), .b_out(c_bout[1]), .b_vld_out(c_bvo[1]),
        .psum_out(c_ps[1]), .psum_vld_out(c_pv[1]), .psum_last_out(c_pl[1]),
        .busy(c_busy[1]), .ovf(c_ovf[1])
    );
    pe_acc u_top (
        .clk(clk), .reset(c_rst), .clear(c_clear), .drain(c_drain), .chain_top(1'b1),
        .a_in(ca[2]), .a_vld_in(c_vld), .b_in(8'd1), .b_vld_in(c_vld),
        .psum_in(24'h0), .psum_vld_in(1'b0), .psum_last_in(1'b0),
        .a_out(c_aout[2]), .a_vld_out(c_avo[2]), .b_out(c_bout[2]), .b_vld_out(c_bvo[2]),
        .psum_out(c_ps[2]), .psum_vld_out(c_pv[2]), .psum_last_out(c_pl[2]),
        .busy(c_busy[2]), .ovf(c_ovf[2])
    );

    typedef struct {
        logic        clr, drn;
        logic [7:0]  a;
        logic        av;
        logic [7:0]  b;
        logic        bv;
        logic [45:0] exp;
    } vec_t;

    function automatic logic [45:0] ev(input logic [7:0] ao, input logic avo, input logic [7:0] bo,
                                       input logic bvo, input logic bsy, input logic pv,
                                       input logic [23:0] ps, input logic pl, input logic ov);
        return {ao, avo, bo, bvo, bsy, pv, ps, pl, ov};
    endfunction

    function automatic logic [45:0] act_main();
        return {a_out, a_vld_out, b_out, b_vld_out, busy, psum_vld_out, psum_out, psum_last_out, ovf};
    endfunction

    vec_t tbl [15];
    int   busy_cnt;
    logic [26:0] col_exp [5];

    initial begin
        tbl[0]  = '{1, 0, 8'd0,   0, 8'd0, 0, ev(8'd0,   0, 8'd0, 0, 0, 0, 24'd0,  0, 0)};
        tbl[1]  = '{0, 0, 8'd3,   1, 8'd4, 1, ev(8'd3,   1, 8'd4, 1, 0, 0, 24'd0,  0, 0)};
        tbl[2]  = '{0, 0, 8'hFE,  1, 8'd5, 1, ev(8'hFE,  1, 8'd5, 1, 0, 0, 24'd0,  0, 0)};
        tbl[3]  = '{0, 0, 8'd7,   1, 8'd7, 1, ev(8'd7,   1, 8'd7, 1, 0, 0, 24'd0,  0, 0)};
        tbl[4]  = '{0, 0, 8'd9,   1, 8'd0, 0, ev(8'd9,   1, 8'd0, 0, 0, 0, 24'd0,  0, 0)};
        tbl[5]  = '{0, 1, 8'd0,   0, 8'd0, 0, ev(8'd0,   0, 8'd0, 0, 1, 0, 24'd0,  0, 0)};
        tbl[6]  = '{0, 0, 8'd0,   0, 8'd0, 0, ev(8'd0,   0, 8'd0, 0, 0, 1, 24'd51, 1, 0)};
        tbl[7]  = '{0, 0, 8'd0,   0, 8'd0, 0, ev(8'd0,   0, 8'd0, 0, 0, 0, 24'd0,  0, 0)};
        tbl[8]  = '{0, 1, 8'd0,   0, 8'd0, 0, ev(8'd0,   0, 8'd0, 0, 1, 0, 24'd0,  0, 0)};
        tbl[9]  = '{0, 0, 8'd0,   0, 8'd0, 0, ev(8'd0,   0, 8'd0, 0, 0, 1, 24'd51, 1, 0)};
        tbl[10] = '{1, 1, 8'd0,   0, 8'd0, 0, ev(8'd0,   0, 8'd0, 0, 1, 0, 24'd0,  0, 0)};
        tbl[11] = '{1, 0, 8'd0,   0, 8'd0, 0, ev(8'd0,   0, 8'd0, 0, 0, 1, 24'd51, 1, 0)};
        tbl[12] = '{0, 1, 8'd0,   0, 8'd0, 0, ev(8'd0,   0, 8'd0, 0, 1, 0, 24'd0,  0, 0)};
        tbl[13] = '{1, 1, 8'd0,   0, 8'd0, 0, ev(8'd0,   0, 8'd0, 0, 0, 1, 24'd51, 1, 0)};
        tbl[14] = '{0, 0, 8'd0,   0, 8'd0, 0, ev(8'd0,   0, 8'd0, 0, 0, 0, 24'd0,  0, 0)};

        col_exp[0] = {1'b1, 1'b0, 24'd0,  1'b0};
        col_exp[1] = {1'b1, 1'b1, 24'd10, 1'b0};
        col_exp[2] = {1'b1, 1'b1, 24'd20, 1'b0};
        col_exp[3] = {1'b0, 1'b1, 24'd30, 1'b1};
        col_exp[4] = {1'b0, 1'b0, 24'd0,  1'b0};

        reset = 1; clear = 1; drain = 1; a_in = 8'd5; a_vld_in = 1; b_in = 8'd6; b_vld_in = 1;
        s_clear = 0; s_drain = 0; s_vld = 0; s_a = 0; s_b = 0;
        c_rst = 1; c_clear = 0; c_drain = 0; c_vld = 0;
        ca[0] = 0; ca[1] = 0; ca[2] = 0;

        repeat (2) @(posedge clk);
        #1;
        chk("reset_outputs", {18'd0, act_main()}, 64'd0);
        chk("reset_busy_ovf", {62'd0, busy, ovf}, 64'd0);
        reset = 0; c_rst = 0;
        clear = 0; drain = 0; a_in = 0; a_vld_in = 0; b_in = 0; b_vld_in = 0;

        for (int i = 0; i < 15; i++) begin
            clear = tbl[i].clr; drain = tbl[i].drn;
            a_in = tbl[i].a; a_vld_in = tbl[i].av; b_in = tbl[i].b; b_vld_in = tbl[i].bv;
            @(posedge clk); #1;
            chk($sformatf("vec%0d", i), {18'd0, act_main()}, {18'd0, tbl[i].exp});
        end
        clear = 0; drain = 0;

        // saturation on a 16-bit accumulator
        s_clear = 1; @(posedge clk); #1; s_clear = 0;
        s_a = 8'd127; s_b = 8'd127; s_vld = 1;
        @(posedge clk); #1; chk("sat_acc1", {48'd0, dut_s.acc}, 64'd16129);
        @(posedge clk); #1; chk("sat_acc2", {48'd0, dut_s.acc}, 64'd32258);
        chk("sat_ovf_pre", {63'd0, s_ovf}, 64'd0);
        @(posedge clk); #1; chk("sat_acc3", {48'd0, dut_s.acc}, 64'd32767);
        chk("sat_ovf", {63'd0, s_ovf}, 64'd1);
        s_vld = 0; s_drain = 1; @(posedge clk); #1; s_drain = 0;
        @(posedge clk); #1; chk("sat_psum", {46'd0, s_pv, s_pl, s_psum}, {46'd0, 2'b11, 16'd32767});
        s_clear = 1; @(posedge clk); #1; s_clear = 0;
        chk("sat_clear_ovf", {63'd0, s_ovf}, 64'd0);
        chk("sat_clear_acc", {48'd0, dut_s.acc}, 64'd0);

        // column drain: load 10/20/30, then common drain
        c_clear = 1; @(posedge clk); #1; c_clear = 0;
        ca[0] = 8'd10; ca[1] = 8'd20; ca[2] = 8'd30; c_vld = 1;
        @(posedge clk); #1; c_vld = 0;
        c_drain = 1; @(posedge clk); #1; c_drain = 0;
        busy_cnt = 0;
        for (int k = 0; k < 5; k++) begin
            if (k > 0) begin @(posedge clk); #1; end
            busy_cnt += int'(c_busy[0]);
            chk($sformatf("col_cyc%0d", k), {37'd0, c_busy[0], c_pv[0], c_ps[0], c_pl[0]}, {37'd0, col_exp[k]});
        end
        chk("col_busy_cycles", busy_cnt, 64'd3);

        // reset during second cycle of bottom drain
        c_drain = 1; @(posedge clk); #1; c_drain = 0;
        @(posedge clk); #1;
        chk("abort_first_word", {39'd0, c_pv[0], c_ps[0]}, {39'd1, 24'd10});
        c_rst = 1; @(posedge clk); #1; c_rst = 0;
        chk("abort_vld", {62'd0, c_pv[0], c_busy[0]}, 64'd0);
        chk("abort_state", {62'd0, u_bot.state}, 64'd0);
        chk("abort_acc", {40'd0, u_bot.acc}, 64'd0);
        @(posedge clk); #1;
        chk("abort_no_more", {38'd0, c_pv[0], c_pl[0], c_ps[0]}, 64'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
